// File: rtl/pkt_defs.sv
// Shared definitions for the packet ingress gate: beat format, tags and FSM state types.
package pkt_defs;

  // Beat layout: [133:132] tag, [131:128] invalid bytes in last beat, [127:0] payload.
  localparam int unsigned PKT_W = 134;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  // MTU-derived beat limits; the +2 leaves margin for header/trailer beats.
  localparam int unsigned BEAT_BYTES    = 16;
  localparam int unsigned MTU_BYTES     = 1536;
  localparam int unsigned MTU_BEATS     = MTU_BYTES / BEAT_BYTES;
  localparam int unsigned MAX_PKT_BEATS = MTU_BEATS + 2;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_PKT,
    IN_DROP
  } in_state_e;

  typedef enum logic {
    OUT_IDLE,
    OUT_SEND
  } out_state_e;

endpackage

// File: rtl/pkt_ring_ram.sv
// Simple dual-port packet buffer: one write port, one synchronous read port (1-cycle latency).
module pkt_ring_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9,
  parameter int unsigned W     = 134
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Storage write and registered read; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_ingress_gate.sv
// Store-and-forward ingress gate: buffers only complete, well-framed packets and
// releases them whole, gated by downstream almost-full at packet start.
module pkt_ingress_gate
  import pkt_defs::*;
#(
  parameter int unsigned DEPTH         = 512,
  parameter int unsigned AW            = 9,
  parameter int unsigned MAX_PKT_WORDS = MAX_PKT_BEATS,
  parameter int unsigned ALF_THRESH    = 128
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_data_valid,
  input  logic [PKT_W-1:0] i_data,
  output logic             o_alf,
  output logic             o_data_valid,
  output logic [PKT_W-1:0] o_data,
  input  logic             i_alf,
  output logic [31:0]      o_cnt_pkt_in,
  output logic [31:0]      o_cnt_drop,
  output logic [31:0]      o_cnt_err
);

  localparam logic [AW:0] PtrOne  = (AW+1)'(1);
  localparam logic [AW:0] DepthW  = (AW+1)'(DEPTH);
  localparam logic [AW:0] MaxPktW = (AW+1)'(MAX_PKT_WORDS);
  localparam logic [AW:0] AlfW    = (AW+1)'(ALF_THRESH);

  in_state_e        in_state_q, in_state_d;
  out_state_e       out_state_q, out_state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      wr_commit_q, wr_commit_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      beat_cnt_q, beat_cnt_d;
  logic [AW:0]      pkts_avail_q, pkts_avail_d;
  logic [31:0]      cnt_pkt_in_q, cnt_pkt_in_d;
  logic [31:0]      cnt_drop_q, cnt_drop_d;
  logic [31:0]      cnt_err_q, cnt_err_d;
  logic             rd_valid_q, rd_valid_d;
  logic             o_data_valid_q, o_data_valid_d;
  logic [PKT_W-1:0] o_data_q, o_data_d;
  logic             o_alf_q, o_alf_d;

  logic             we;
  logic [AW-1:0]    waddr;
  logic             re;
  logic [PKT_W-1:0] ram_rdata;
  logic [1:0]       in_tag;
  logic [1:0]       rd_tag;
  logic             commit;
  logic             pkt_done;
  logic             head_take;
  logic [AW:0]      free_commit;
  logic [AW:0]      free_d;

  assign in_tag = i_data[PKT_W-1 -: 2];
  assign rd_tag = ram_rdata[PKT_W-1 -: 2];

  // Heads are always placed at wr_commit, so room is measured from the committed point.
  assign free_commit = DepthW - (wr_commit_q - rd_ptr_q);
  assign free_d      = DepthW - (wr_ptr_d - rd_ptr_d);
  assign o_alf_d     = free_d < AlfW;

  // Input FSM: framing checks, buffer writes, rollback and commit.
  always_comb begin
    in_state_d   = in_state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    beat_cnt_d   = beat_cnt_q;
    cnt_pkt_in_d = cnt_pkt_in_q;
    cnt_drop_d   = cnt_drop_q;
    cnt_err_d    = cnt_err_q;
    we           = 1'b0;
    waddr        = wr_ptr_q[AW-1:0];
    commit       = 1'b0;
    head_take    = 1'b0;

    if (i_data_valid) begin
      unique case (in_state_q)
        IN_IDLE: begin
          if (in_tag == TAG_HEAD) begin
            head_take = 1'b1;
          end else begin
            cnt_err_d = cnt_err_q + 32'd1;
          end
        end
        IN_PKT: begin
          case (in_tag)
            TAG_HEAD: begin
              wr_ptr_d  = wr_commit_q;
              cnt_err_d = cnt_err_q + 32'd1;
              head_take = 1'b1;
            end
            TAG_BODY, TAG_TAIL: begin
              if (beat_cnt_q >= MaxPktW) begin
                // Oversize: discard the partial packet and skip to its end.
                wr_ptr_d   = wr_commit_q;
                cnt_err_d  = cnt_err_q + 32'd1;
                in_state_d = IN_DROP;
              end else begin
                we         = 1'b1;
                wr_ptr_d   = wr_ptr_q + PtrOne;
                beat_cnt_d = beat_cnt_q + PtrOne;
                if (in_tag == TAG_TAIL) begin
                  wr_commit_d  = wr_ptr_q + PtrOne;
                  commit       = 1'b1;
                  cnt_pkt_in_d = cnt_pkt_in_q + 32'd1;
                  in_state_d   = IN_IDLE;
                end
              end
            end
            default: begin
              wr_ptr_d   = wr_commit_q;
              cnt_err_d  = cnt_err_q + 32'd1;
              in_state_d = IN_DROP;
            end
          endcase
        end
        IN_DROP: begin
          if (in_tag == TAG_HEAD) begin
            head_take = 1'b1;
          end else if (in_tag == TAG_TAIL) begin
            in_state_d = IN_IDLE;
          end
        end
        default: in_state_d = IN_IDLE;
      endcase

      // Common head handling: start a new packet only if a maximum-size one fits.
      if (head_take) begin
        if (free_commit >= MaxPktW) begin
          we         = 1'b1;
          waddr      = wr_commit_q[AW-1:0];
          wr_ptr_d   = wr_commit_q + PtrOne;
          beat_cnt_d = PtrOne;
          in_state_d = IN_PKT;
        end else begin
          wr_ptr_d   = wr_commit_q;
          cnt_drop_d = cnt_drop_q + 32'd1;
          in_state_d = IN_DROP;
        end
      end
    end
  end

  // Output FSM: read whole packets; stop when the tail word comes out of the RAM.
  always_comb begin
    out_state_d = out_state_q;
    rd_ptr_d    = rd_ptr_q;
    re          = 1'b0;
    pkt_done    = 1'b0;

    unique case (out_state_q)
      OUT_IDLE: begin
        if ((pkts_avail_q != '0) && !i_alf) begin
          re          = 1'b1;
          rd_ptr_d    = rd_ptr_q + PtrOne;
          out_state_d = OUT_SEND;
        end
      end
      OUT_SEND: begin
        // The read issued last cycle was the tail: suppress this cycle's read.
        if (rd_valid_q && (rd_tag == TAG_TAIL)) begin
          pkt_done    = 1'b1;
          out_state_d = OUT_IDLE;
        end else begin
          re       = 1'b1;
          rd_ptr_d = rd_ptr_q + PtrOne;
        end
      end
      default: out_state_d = OUT_IDLE;
    endcase
  end

  // Packet-available count and output staging.
  always_comb begin
    pkts_avail_d = pkts_avail_q;
    case ({commit, pkt_done})
      2'b10:   pkts_avail_d = pkts_avail_q + PtrOne;
      2'b01:   pkts_avail_d = pkts_avail_q - PtrOne;
      default: pkts_avail_d = pkts_avail_q;
    endcase
    rd_valid_d     = re;
    o_data_valid_d = rd_valid_q;
    o_data_d       = rd_valid_q ? ram_rdata : '0;
  end

  // State, pointer and counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_state_q     <= IN_IDLE;
      out_state_q    <= OUT_IDLE;
      wr_ptr_q       <= '0;
      wr_commit_q    <= '0;
      rd_ptr_q       <= '0;
      beat_cnt_q     <= '0;
      pkts_avail_q   <= '0;
      cnt_pkt_in_q   <= '0;
      cnt_drop_q     <= '0;
      cnt_err_q      <= '0;
      rd_valid_q     <= 1'b0;
      o_data_valid_q <= 1'b0;
      o_data_q       <= '0;
      o_alf_q        <= 1'b0;
    end else begin
      in_state_q     <= in_state_d;
      out_state_q    <= out_state_d;
      wr_ptr_q       <= wr_ptr_d;
      wr_commit_q    <= wr_commit_d;
      rd_ptr_q       <= rd_ptr_d;
      beat_cnt_q     <= beat_cnt_d;
      pkts_avail_q   <= pkts_avail_d;
      cnt_pkt_in_q   <= cnt_pkt_in_d;
      cnt_drop_q     <= cnt_drop_d;
      cnt_err_q      <= cnt_err_d;
      rd_valid_q     <= rd_valid_d;
      o_data_valid_q <= o_data_valid_d;
      o_data_q       <= o_data_d;
      o_alf_q        <= o_alf_d;
    end
  end

  pkt_ring_ram #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .W    (PKT_W)
  ) u_ram (
    .clk_i  (i_clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(i_data),
    .re_i   (re),
    .raddr_i(rd_ptr_q[AW-1:0]),
    .rdata_o(ram_rdata)
  );

  assign o_alf        = o_alf_q;
  assign o_data_valid = o_data_valid_q;
  assign o_data       = o_data_q;
  assign o_cnt_pkt_in = cnt_pkt_in_q;
  assign o_cnt_drop   = cnt_drop_q;
  assign o_cnt_err    = cnt_err_q;

endmodule

// File: tb/tb_pkt_ingress_gate.sv
// Scoreboard bench for pkt_ingress_gate: expected beats are queued as packets are driven
// and popped as the gate emits them.
module tb_pkt_ingress_gate;
  import pkt_defs::*;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_data_valid = 1'b0;
  logic [133:0] i_data = '0;
  logic         o_alf;
  logic         o_data_valid;
  logic [133:0] o_data;
  logic         i_alf = 1'b0;
  logic [31:0]  o_cnt_pkt_in;
  logic [31:0]  o_cnt_drop;
  logic [31:0]  o_cnt_err;

  int unsigned  total = 0;
  int unsigned  bad = 0;
  int unsigned  exp_pkt = 0;
  int unsigned  exp_drop = 0;
  int unsigned  exp_err = 0;
  logic [133:0] exp_q[$];
  bit           prev_mid = 1'b0;
  bit           have;

  pkt_ingress_gate dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data_valid(i_data_valid),
    .i_data      (i_data),
    .o_alf       (o_alf),
    .o_data_valid(o_data_valid),
    .o_data      (o_data),
    .i_alf       (i_alf),
    .o_cnt_pkt_in(o_cnt_pkt_in),
    .o_cnt_drop  (o_cnt_drop),
    .o_cnt_err   (o_cnt_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [133:0] got, input logic [133:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [133:0] mk_beat(input logic [1:0] tag, input int id, input int idx);
    logic [3:0] inv;
    inv = (tag == TAG_TAIL) ? 4'(id) : 4'h0;
    return {tag, inv, 32'(id), 32'(idx), $urandom, $urandom};
  endfunction

  task automatic put(input logic [133:0] d);
    i_data_valid = 1'b1;
    i_data = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_pkt(input int n, input bit keep, input int id);
    logic [133:0] d;
    logic [1:0]   tag;
    for (int i = 0; i < n; i++) begin
      tag = (i == 0) ? TAG_HEAD : ((i == n - 1) ? TAG_TAIL : TAG_BODY);
      d = mk_beat(tag, id, i);
      if (keep) exp_q.push_back(d);
      put(d);
    end
    i_data_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge i_clk);
      n++;
    end
    repeat (4) @(posedge i_clk);
    #1;
    check(tag, 134'(exp_q.size()), 134'(0));
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_pkt"}, 134'(o_cnt_pkt_in), 134'(exp_pkt));
    check({tag, "_drop"}, 134'(o_cnt_drop), 134'(exp_drop));
    check({tag, "_err"}, 134'(o_cnt_err), 134'(exp_err));
  endtask

  // Output monitor: every emitted beat must match the scoreboard; packets have no gaps.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (prev_mid) check("gap", 134'(o_data_valid), 134'(1));
      if (o_data_valid) begin
        have = exp_q.size() != 0;
        check("sb_avail", 134'(have), 134'(1));
        if (have) check("beat", o_data, exp_q.pop_front());
      end
      prev_mid = o_data_valid && (o_data[133:132] != TAG_TAIL);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got still running want finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("rst_valid", 134'(o_data_valid), 134'(0));
    check("rst_data", o_data, 134'(0));
    check("rst_alf", 134'(o_alf), 134'(0));
    check_cnts("rst");

    // 1: single 4-beat packet, first beat two cycles after the release decision
    send_pkt(4, 1'b1, 1);
    exp_pkt++;
    @(negedge i_clk);
    @(negedge i_clk);
    check("lat_early", 134'(o_data_valid), 134'(0));
    @(negedge i_clk);
    check("lat_first", 134'(o_data_valid), 134'(1));
    drain("drain_t1");
    check_cnts("t1");
    check("t1_alf", 134'(o_alf), 134'(0));

    // 2: head interrupted by a new head -> first packet rolled back
    put(mk_beat(TAG_HEAD, 20, 0));
    put(mk_beat(TAG_BODY, 20, 1));
    put(mk_beat(TAG_BODY, 20, 2));
    send_pkt(3, 1'b1, 21);
    exp_err++;
    exp_pkt++;
    drain("drain_t2");
    check_cnts("t2");

    // 3: 99-beat oversize packet dropped, following packet intact
    send_pkt(99, 1'b0, 30);
    exp_err++;
    send_pkt(4, 1'b1, 31);
    exp_pkt++;
    drain("drain_t3");
    check_cnts("t3");

    // 4: fill while downstream is almost full; o_alf threshold and no-room drop
    i_alf = 1'b1;
    for (int p = 0; p < 6; p++) send_pkt(64, 1'b1, 40 + p);
    check("alf_free128", 134'(o_alf), 134'(0));
    send_pkt(64, 1'b1, 46);
    check("alf_free64", 134'(o_alf), 134'(1));
    send_pkt(64, 1'b0, 47);
    exp_pkt += 7;
    exp_drop++;
    check_cnts("t4");
    i_alf = 1'b0;
    drain("drain_t4");
    check("t4_alf_fall", 134'(o_alf), 134'(0));

    // 5: commit coincides with an output tail; i_alf rising mid-packet is ignored
    send_pkt(4, 1'b1, 50);
    send_pkt(5, 1'b1, 51);
    exp_pkt += 2;
    repeat (3) @(posedge i_clk);
    #1;
    i_alf = 1'b1;
    drain("drain_t5");
    i_alf = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    check_cnts("t5");

    // 6: reset mid-packet clears everything; a fresh packet passes afterwards
    put(mk_beat(TAG_HEAD, 60, 0));
    put(mk_beat(TAG_BODY, 60, 1));
    i_data_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    exp_pkt = 0;
    exp_drop = 0;
    exp_err = 0;
    check("t6_valid", 134'(o_data_valid), 134'(0));
    check("t6_data", o_data, 134'(0));
    check("t6_alf", 134'(o_alf), 134'(0));
    check_cnts("t6_rst");
    send_pkt(2, 1'b1, 61);
    exp_pkt++;
    drain("drain_t6");
    check_cnts("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
